// File: rtl/arbitrated_merge_pkg.sv
// rtl/arbitrated_merge_pkg.sv - shared helpers for the arbitrated merge
package arbitrated_merge_pkg;

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - round-robin grant selection owning the priority pointer
module round_robin_arbiter
    import arbitrated_merge_pkg::*;
#(
    parameter int p_n = 2,
    localparam int p_iw = $clog2(p_n)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [p_n-1:0]  req,
    input  logic            en,
    output logic [p_iw-1:0] grant,
    output logic            grant_val
);

    logic [p_iw-1:0] ptr;
    int              idx;

    // Scan from farthest offset down so the requester closest to ptr wins.
    always_comb begin
        grant     = '0;
        grant_val = 1'b0;
        idx       = 0;
        for (int i = p_n - 1; i >= 0; i--) begin
            idx = wrap_add(int'(ptr), i, p_n);
            if (req[idx]) begin
                grant     = p_iw'(idx);
                grant_val = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= p_iw'(wrap_add(int'(grant), 1, p_n));
        end
    end

endmodule

// File: rtl/arbitrated_merge.sv
// rtl/arbitrated_merge.sv - merges N valid/ready streams into one registered output
module arbitrated_merge
    import arbitrated_merge_pkg::*;
#(
    parameter int p_nbits   = 1,
    parameter int p_ninputs = 2,
    localparam int p_iw = $clog2(p_ninputs)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [p_ninputs-1:0] recv_val,
    input  logic [p_nbits-1:0]   recv_msg [p_ninputs-1:0],
    output logic [p_ninputs-1:0] recv_rdy,
    output logic                 send_val,
    output logic [p_nbits-1:0]   send_msg,
    output logic [p_iw-1:0]      send_src,
    input  logic                 send_rdy
);

    logic               full;
    logic [p_nbits-1:0] msg_q;
    logic [p_iw-1:0]    src_q;
    logic [p_iw-1:0]    grant;
    logic               grant_val;
    logic               can_accept;
    logic               xfer;

    assign can_accept = !full || send_rdy;

    always_comb begin
        recv_rdy = '0;
        if (reset && can_accept && grant_val) begin
            recv_rdy[grant] = 1'b1;
        end
    end

    assign xfer = |recv_rdy;

    round_robin_arbiter #(
        .p_n (p_ninputs)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (recv_val),
        .en        (xfer),
        .grant     (grant),
        .grant_val (grant_val)
    );

    // A load wins over a dequeue in the same cycle, giving one message per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full  <= 1'b0;
            msg_q <= '0;
            src_q <= '0;
        end else if (xfer) begin
            full  <= 1'b1;
            msg_q <= recv_msg[grant];
            src_q <= grant;
        end else if (full && send_rdy) begin
            full <= 1'b0;
        end
    end

    assign send_val = full;
    assign send_msg = msg_q;
    assign send_src = src_q;

endmodule

// File: tb/tb_arbitrated_merge.sv
// tb/tb_arbitrated_merge.sv - self-checking bench for arbitrated_merge
module tb_arbitrated_merge;

    localparam int NB = 8;
    localparam int NI = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] recv_val;
    logic [NB-1:0] recv_msg [NI-1:0];
    logic [NI-1:0] recv_rdy;
    logic          send_val;
    logic [NB-1:0] send_msg;
    logic [1:0]    send_src;
    logic          send_rdy;

    int checks = 0;
    int errors = 0;

    logic          m_full;
    logic [NB-1:0] m_msg;
    logic [1:0]    m_src;
    int            m_ptr;
    logic [NI-1:0] last_rdy;
    int            srcs [$];

    always #5 clk = ~clk;

    arbitrated_merge #(.p_nbits(NB), .p_ninputs(NI)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_msg (recv_msg),
        .recv_rdy (recv_rdy),
        .send_val (send_val),
        .send_msg (send_msg),
        .send_src (send_src),
        .send_rdy (send_rdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive, compare against the model, then advance the model at the edge.
    task automatic cycle(input logic rst, input logic [NI-1:0] val, input logic sr);
        int g;
        logic [NI-1:0] exp_rdy;
        reset = rst;
        recv_val = val;
        send_rdy = sr;
        #1;
        g = -1;
        for (int k = NI - 1; k >= 0; k--)
            if (val[(m_ptr + k) % NI]) g = (m_ptr + k) % NI;
        exp_rdy = (rst && (!m_full || sr) && g >= 0) ? NI'(1 << g) : '0;
        chk("send_val", 32'(send_val), 32'(m_full));
        if (m_full) begin
            chk("send_msg", 32'(send_msg), 32'(m_msg));
            chk("send_src", 32'(send_src), 32'(m_src));
        end
        chk("recv_rdy", 32'(recv_rdy), 32'(exp_rdy));
        last_rdy = recv_rdy;
        if (rst && m_full && sr) srcs.push_back(int'(m_src));
        @(posedge clk);
        if (!rst) begin
            m_full = 1'b0; m_msg = '0; m_src = '0; m_ptr = 0;
        end else if (exp_rdy != '0) begin
            m_full = 1'b1; m_msg = recv_msg[g]; m_src = 2'(g); m_ptr = (g + 1) % NI;
        end else if (m_full && sr) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        m_full = 1'b0; m_msg = '0; m_src = '0; m_ptr = 0;
        reset = 1'b0; recv_val = '0; send_rdy = 1'b0;
        recv_msg[0] = 8'hA5; recv_msg[1] = 8'h3C; recv_msg[2] = 8'h11; recv_msg[3] = 8'h7E;
        @(negedge clk);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1111, 1'b1);
        chk("reset_send_val", 32'(send_val), 32'd0);
        chk("reset_send_msg", 32'(send_msg), 32'd0);
        chk("reset_send_src", 32'(send_src), 32'd0);
        chk("reset_recv_rdy", 32'(last_rdy), 32'd0);

        // Single input
        cycle(1'b1, 4'b0001, 1'b1);
        chk("single_val", 32'(send_val), 32'd1);
        chk("single_msg", 32'(send_msg), 32'hA5);
        chk("single_src", 32'(send_src), 32'd0);
        cycle(1'b1, 4'b0000, 1'b1);
        chk("drain_val", 32'(send_val), 32'd0);

        // Fairness, ptr now 1: grant input 3 alone so ptr returns to 0
        cycle(1'b1, 4'b1000, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        srcs.delete();
        for (int i = 0; i < 7; i++) cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        chk("fair_count", 32'(srcs.size()), 32'd7);
        for (int i = 0; i < 6; i++)
            if (i < srcs.size()) chk("fair_src", 32'(srcs[i]), 32'(i % 4));

        // Backpressure: ptr is 3; load 0x11 from input 2 only
        cycle(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b1011, 1'b0);
            chk("bp_rdy", 32'(last_rdy), 32'd0);
            chk("bp_msg", 32'(send_msg), 32'h11);
            chk("bp_src", 32'(send_src), 32'd2);
        end
        cycle(1'b1, 4'b1011, 1'b1);
        chk("bp_release_rdy", 32'(last_rdy), 32'b1000);
        chk("bp_next_src", 32'(send_src), 32'd3);
        cycle(1'b1, 4'b0000, 1'b1);

        // Wrap: ptr is 0; grant input 2 to set ptr=3, then 1001
        cycle(1'b1, 4'b0100, 1'b1);
        cycle(1'b1, 4'b1001, 1'b1);
        chk("wrap_first", 32'(last_rdy), 32'b1000);
        cycle(1'b1, 4'b1001, 1'b1);
        chk("wrap_second", 32'(last_rdy), 32'b0001);

        // Reset mid-stream while full
        cycle(1'b0, 4'b1111, 1'b1);
        chk("rst_mid_rdy", 32'(last_rdy), 32'd0);
        chk("rst_mid_val", 32'(send_val), 32'd0);
        cycle(1'b1, 4'b1010, 1'b1);
        chk("rst_mid_grant", 32'(last_rdy), 32'b0010);

        // Idle after grant to input 1: ptr stays 2
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0000, 1'b1);
        chk("idle_val", 32'(send_val), 32'd0);
        cycle(1'b1, 4'b1111, 1'b1);
        chk("idle_ptr_grant", 32'(last_rdy), 32'b0100);
        cycle(1'b1, 4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitrated_merge.md
ARBITRATED_MERGE -- requirements
Module: arbitrated_merge

Interface
REQ-001 Parameter p_nbits, default 1: message width in bits.
REQ-002 Parameter p_ninputs, default 2: number of input streams; legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 recv_val  input  p_ninputs  per-input message-valid bits.
REQ-006 recv_msg  input  unpacked array [p_ninputs-1:0] of p_nbits  per-input message payloads.
REQ-007 recv_rdy  output  p_ninputs  per-input ready bits.
REQ-008 send_val  output  1  output message valid.
REQ-009 send_msg  output  p_nbits  output message payload.
REQ-010 send_src  output  $clog2(p_ninputs)  index of the input that supplied send_msg.
REQ-011 send_rdy  input  1  downstream ready.

Function
REQ-012 A transfer on any port occurs only in a cycle where val and rdy are both 1.
REQ-013 Single-entry output register holds {msg, src}; send_val is 1 exactly when the register is full.
REQ-014 can_accept = (register empty) OR (send_val AND send_rdy).
REQ-015 Round-robin arbiter grants the requesting input with the lowest index at or above priority pointer ptr, wrapping from p_ninputs-1 to 0.
REQ-016 recv_rdy[i] = can_accept AND (grant == i); at most one recv_rdy bit is 1 per cycle.
REQ-017 recv_rdy is 0 for every input whose recv_val is 0.
REQ-018 On an input transfer from input g: register loads recv_msg[g] and src g at the clock edge.
REQ-019 On the same edge, ptr becomes (g+1) mod p_ninputs.
REQ-020 Latency from input transfer to send_val=1 is one cycle.
REQ-021 Simultaneous dequeue and enqueue in one cycle sustains one message per cycle.
REQ-022 Dequeue with no enqueue leaves the register empty (send_val=0 next cycle).
REQ-023 With no recv_val set, ptr and the register content are unchanged except for a dequeue.
REQ-024 Full register with send_rdy=0: register, send_msg and send_src hold stable; all recv_rdy=0.
REQ-025 send_msg and send_src have no combinational path from recv_*.
REQ-026 recv_rdy may depend combinationally on recv_val and send_rdy.
REQ-027 recv_msg is ignored for inputs that are not granted.

Reset
REQ-028 While reset=0 at a clock edge: register marked empty, ptr=0.
REQ-029 Reset values: send_val=0, send_msg=0, send_src=0.
REQ-030 recv_rdy is forced to all 0 in any cycle with reset=0.
REQ-031 Reset asserted mid-operation discards any buffered message, with no transfer completed that cycle.

Structure
REQ-032 No shared-package typedefs are required; the widths are derived locally from the parameters.
REQ-033 Arbitration is implemented in one sub-module, round_robin_arbiter (inputs req, en; outputs grant index and grant_val), which owns ptr.
REQ-034 The output register and handshake logic live in arbitrated_merge.

Verification
REQ-035 Single input: p_nbits=8, p_ninputs=4, recv_val=0001, msg0=0xA5, send_rdy=1 -> next cycle send_val=1, send_msg=0xA5, send_src=0.
REQ-036 Fairness: all four inputs valid continuously, send_rdy=1 -> send_src sequence is 0,1,2,3,0,1 with one message per cycle.
REQ-037 Backpressure: register holds 0x11 from src 2, send_rdy=0 for 3 cycles -> send_msg/src stable, recv_rdy=0000 throughout; send_rdy=1 -> 0x11 dequeued, next input accepted the same cycle.
REQ-038 Wrap: ptr=3, recv_val=1001 -> input 3 is granted first, then input 0.
REQ-039 Reset mid-stream: reset=0 for one cycle while full -> next cycle send_val=0, ptr=0; with recv_val=1010, input 1 is granted first.
REQ-040 Idle: recv_val=0000 for 5 cycles after a grant to input 1 -> ptr remains 2, send_val=0 after the drain.
